// File: rtl/sar_pkg.sv
// Shared definitions for the SAR sequencer.
//   sar_state_t    : conversion FSM states
//   SAMPLE_W_DEF   : default width of the sample-duration configuration
//   SETTLE_W_DEF   : default width of the per-bit settle configuration
//   idx_w()        : width of the bit-index register, clog2(Ndac), at least 1
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_TRIAL  = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_t;

    localparam int SAMPLE_W_DEF = 8;
    localparam int SETTLE_W_DEF = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_result_reg.sv
// Valid/ready output register for the SAR result, with sticky overrun flag.
//   clk, rst_n     : clock, async active-low reset
//   load           : one-cycle strobe from the sequencer's DONE state
//   load_code/inv  : code and polarity to capture on load
//   result_ready   : consumer accepts the held result
//   overrun_clr    : clears overrun (a same-edge set wins)
//   result*        : held result, polarity and valid
//   overrun        : an unconsumed result was overwritten
module sar_result_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_code,
    input  logic         load_inv,
    input  logic         result_ready,
    input  logic         overrun_clr,
    output logic [W-1:0] result,
    output logic         result_inv,
    output logic         result_valid,
    output logic         overrun
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_inv   <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // A new result beats a same-edge consume: valid stays up with new data.
            if (load) begin
                result       <= load_code;
                result_inv   <= load_inv;
                result_valid <= 1'b1;
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end

            if (load && result_valid && !result_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sar_sequencer.sv
// Successive-approximation sequencer for the capacitor-array drivers.
// One conversion per accepted start: sample phase, then one trial per DAC
// bit (MSB first), each held settle_cycles+1 cycles before the comparator
// decision is taken.
//   clk, rst_n        : clock, async active-low reset
//   start             : conversion request, honoured only in IDLE
//   sample_cycles     : sample-phase length (0 behaves as 1)
//   settle_cycles     : extra wait cycles per trial bit
//   chop_en           : toggle drive polarity on this conversion
//   comp_out          : comparator decision (1 = keep, before polarity)
//   busy, sample      : conversion in progress / sampling switch enable
//   dac_state         : trial code to the capacitor drivers
//   dac_drive_invert  : drive polarity, constant for a whole conversion
//   result*, overrun* : output register (see sar_result_reg)
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int Ndac     = 16,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] sample_cycles,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                chop_en,
    input  logic                comp_out,
    output logic                busy,
    output logic                sample,
    output logic [Ndac-1:0]     dac_state,
    output logic                dac_drive_invert,
    output logic [Ndac-1:0]     result,
    output logic                result_inv,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int IDX_W = idx_w(Ndac);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(Ndac - 1);

    sar_state_t          state_q,      state_d;
    logic                sample_q,     sample_d;
    logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [SETTLE_W-1:0] settle_cfg_q, settle_cfg_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [Ndac-1:0]     dac_q,        dac_d;
    logic                inv_q,        inv_d;
    logic [IDX_W-1:0]    idx_m1;
    logic                done;

    assign idx_m1 = idx_q - IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        sample_cnt_d = sample_cnt_q;
        settle_cnt_d = settle_cnt_q;
        settle_cfg_d = settle_cfg_q;
        idx_d        = idx_q;
        dac_d        = dac_q;
        inv_d        = inv_q;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SAMPLE;
                    sample_d     = 1'b1;
                    sample_cnt_d = (sample_cycles == '0) ? SAMPLE_W'(1) : sample_cycles;
                    settle_cfg_d = settle_cycles;
                    inv_d        = chop_en ? ~inv_q : 1'b0;
                end
            end

            // Counter holds the remaining sample cycles; the edge that sees 1
            // ends the phase and presents the MSB trial.
            ST_SAMPLE: begin
                if (sample_cnt_q <= SAMPLE_W'(1)) begin
                    state_d          = ST_TRIAL;
                    sample_d         = 1'b0;
                    sample_cnt_d     = '0;
                    dac_d            = '0;
                    dac_d[Ndac-1]    = 1'b1;
                    settle_cnt_d     = settle_cfg_q;
                end else begin
                    sample_cnt_d = sample_cnt_q - SAMPLE_W'(1);
                end
            end

            ST_TRIAL: begin
                if (settle_cnt_q == '0) begin
                    if (!(comp_out ^ inv_q))
                        dac_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d         = idx_m1;
                        dac_d[idx_m1] = 1'b1;
                        settle_cnt_d  = settle_cfg_q;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                dac_d   = '0;
                idx_d   = IDX_TOP;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q     <= 1'b0;
            sample_cnt_q <= '0;
            settle_cnt_q <= '0;
            settle_cfg_q <= '0;
            idx_q        <= IDX_TOP;
            dac_q        <= '0;
            inv_q        <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            sample_cnt_q <= sample_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            settle_cfg_q <= settle_cfg_d;
            idx_q        <= idx_d;
            dac_q        <= dac_d;
            inv_q        <= inv_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign sample           = sample_q;
    assign dac_state        = dac_q;
    assign dac_drive_invert = inv_q;

    // DONE already holds the final code in dac_q, so it is captured directly.
    sar_result_reg #(.W(Ndac)) u_result (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (done),
        .load_code    (dac_q),
        .load_inv     (inv_q),
        .result_ready (result_ready),
        .overrun_clr  (overrun_clr),
        .result       (result),
        .result_inv   (result_inv),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

endmodule

// File: tb/tb_sar_sequencer.sv
module tb_sar_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   sample_cycles;
    logic [3:0]   settle_cycles;
    logic         chop_en;
    logic         comp_out;
    logic         busy, sample;
    logic [N-1:0] dac_state;
    logic         dac_drive_invert;
    logic [N-1:0] result;
    logic         result_inv, result_valid;
    logic         result_ready;
    logic         overrun, overrun_clr;

    // Reference model state
    logic         m_inv   = 1'b0;   // polarity expected for the current conversion
    logic         m_valid = 1'b0;
    logic         m_ovr   = 1'b0;
    logic [N-1:0] cmp_tgt = '0;     // analog input, expressed as its ideal code

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Comparator plant: keep the trial bit when trial <= input, flipped by the
    // polarity the model expects for this conversion.
    assign comp_out = (dac_state <= cmp_tgt) ^ m_inv;

    sar_sequencer #(.Ndac(N), .SAMPLE_W(8), .SETTLE_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .sample_cycles    (sample_cycles),
        .settle_cycles    (settle_cycles),
        .chop_en          (chop_en),
        .comp_out         (comp_out),
        .busy             (busy),
        .sample           (sample),
        .dac_state        (dac_state),
        .dac_drive_invert (dac_drive_invert),
        .result           (result),
        .result_inv       (result_inv),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .overrun          (overrun),
        .overrun_clr      (overrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Trial code presented while bit j is under test: bits above j already
    // resolved to the input code, bit j set, lower bits clear.
    function automatic logic [N-1:0] trial_code(input logic [N-1:0] tgt, input int j);
        int e;
        e = (int'(tgt) & ~((1 << (j + 1)) - 1)) | (1 << j);
        return N'(e);
    endfunction

    // One conversion from IDLE. Called #1 after a rising edge.
    task automatic run_conv(input int s, input int t, input logic [N-1:0] tgt,
                            input logic chop, input logic rdy_hold,
                            input logic consume, input logic poke);
        int se, lat, sample_hi;
        logic [N-1:0] exp_dac;
        se        = (s == 0) ? 1 : s;
        lat       = se + N * (t + 1) + 1;
        sample_hi = 0;
        cmp_tgt       = tgt;
        sample_cycles = 8'(s);
        settle_cycles = 4'(t);
        chop_en       = chop;
        result_ready  = rdy_hold;
        start         = 1'b1;
        m_inv         = chop ? ~m_inv : 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        chk("inv_on_start", dac_drive_invert, m_inv);
        chk("dac_on_start", dac_state, 0);
        if (sample) sample_hi++;
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            if (sample) sample_hi++;
            if (n < se)             exp_dac = '0;
            else if (n < lat - 1)   exp_dac = trial_code(tgt, N - 1 - (n - se) / (t + 1));
            else if (n == lat - 1)  exp_dac = tgt;
            else                    exp_dac = '0;
            chk("dac_state", dac_state, exp_dac);
            if (n == lat - 1) begin
                chk("busy_in_done", busy, 1);
                chk("inv_held", dac_drive_invert, m_inv);
                if (poke) start = 1'b1;   // lands on the DONE edge: must be ignored
            end
            if (poke && n == 2) begin
                start = 1'b1;
                sample_cycles = 8'd0;
                settle_cycles = 4'd0;
            end
            if (poke && n == 3) start = 1'b0;
            if (n == 1) cmp_tgt = tgt;
        end
        start        = 1'b0;
        result_ready = 1'b0;
        m_ovr        = m_ovr | (m_valid & ~rdy_hold);
        m_valid      = 1'b1;
        chk("sample_len", sample_hi, se);
        chk("busy_after", busy, 0);
        chk("result_valid", result_valid, 1);
        chk("result", result, tgt);
        chk("result_inv", result_inv, m_inv);
        chk("overrun", overrun, m_ovr);
        if (poke) begin
            repeat (2) begin
                @(posedge clk); #1;
                chk("busy_ignored_start", busy, 0);
            end
        end
        if (consume) begin
            result_ready = 1'b1;
            @(posedge clk); #1;
            result_ready = 1'b0;
            m_valid = 1'b0;
            chk("valid_consumed", result_valid, 0);
        end
    endtask

    task automatic clr_overrun();
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        m_ovr = 1'b0;
        chk("overrun_clr", overrun, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_sample"}, sample, 0);
        chk({tag, "_dac"},    dac_state, 0);
        chk({tag, "_inv"},    dac_drive_invert, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_rinv"},   result_inv, 0);
        chk({tag, "_valid"},  result_valid, 0);
        chk({tag, "_ovr"},    overrun, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        sample_cycles = '0;
        settle_cycles = '0;
        chop_en       = 1'b0;
        result_ready  = 1'b0;
        overrun_clr   = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic conversion, then long settle, then chopped pair
        run_conv(2, 0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        run_conv(2, 3, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        run_conv(2, 0, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0);
        run_conv(2, 0, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0);

        // Zero sample length plus starts while busy and on the DONE edge
        run_conv(0, 1, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);

        // Overrun, clear, then a consume that races a new result
        run_conv(1, 0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        run_conv(3, 1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_overrun();
        run_conv(1, 0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
        run_conv(1, 0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the bit-2 trial
        cmp_tgt       = 4'b1101;
        sample_cycles = 8'd1;
        settle_cycles = 4'd2;
        chop_en       = 1'b1;
        m_inv         = ~m_inv;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_dac", dac_state, trial_code(4'b1101, 2));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        m_inv = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_conv(2, 1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized conversions
        for (int i = 0; i < 25; i++) begin
            run_conv(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                     N'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom));
            if (m_ovr) clr_overrun();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
Successive-approximation sequencer for the capacitor-array drivers. It runs one conversion per start request: a sample phase, then one trial per DAC bit from MSB to LSB, each trial followed by a settle wait and a comparator decision. It drives the dac_state bus and the dac_drive_invert control of the per-bit capacitor drivers, supports optional polarity chopping between conversions, and returns the result through a valid/ready output register.

Parameters:
Ndac, 16, number of DAC bits; the width of dac_state and result.
SAMPLE_W, 8, width of the sample-duration configuration.
SETTLE_W, 4, width of the per-bit settle configuration.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  conversion request; sampled only in IDLE.
sample_cycles  in  SAMPLE_W  sample-phase length; latched on accepted start; 0 is treated as 1.
settle_cycles  in  SETTLE_W  extra wait cycles per bit; latched on accepted start.
chop_en  in  1  toggle polarity on each conversion; latched on accepted start.
comp_out  in  1  comparator decision (1 = keep trial bit when not inverted).
busy  out  1  high from the accepted start until the DONE state exits.
sample  out  1  sampling-switch enable.
dac_state  out  Ndac  trial code presented to the capacitor drivers.
dac_drive_invert  out  1  polarity for the current conversion; stable while busy.
result  out  Ndac  final code.
result_inv  out  1  polarity used for result.
result_valid  out  1  result available.
result_ready  in  1  consumer accepts result.
overrun  out  1  sticky flag: an unconsumed result was overwritten.
overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, sample, dac_state, dac_drive_invert, result, result_inv, result_valid and overrun are all 0. Bit index = Ndac-1. Counters = 0.
- States: IDLE, SAMPLE, TRIAL, DONE.
- IDLE: dac_state=0, sample=0.
  - On start=1: latch the configuration; busy=1; sample=1; go to SAMPLE; load the sample counter with max(sample_cycles,1).
  - If chop_en (latched) is 1, dac_drive_invert toggles on the same edge; otherwise it is cleared to 0.
- SAMPLE: sample stays high for exactly max(sample_cycles,1) cycles. On the last edge:
  - sample goes to 0;
  - dac_state becomes the MSB only (bit Ndac-1 set);
  - the settle counter loads settle_cycles;
  - the state goes to TRIAL.
- TRIAL: each bit takes settle_cycles+1 cycles. On the edge where the settle counter is 0:
  - decision d = comp_out XOR dac_drive_invert;
  - if d=0, clear the current bit;
  - if index=0, go to DONE; otherwise decrement the index, set the next lower bit, and reload the settle counter on the same edge.
- DONE (one cycle): result<=dac_state; result_inv<=dac_drive_invert; result_valid<=1. If result_valid was already 1 and result_ready=0 on that edge, set overrun. Then busy=0, dac_state=0, index reset, go to IDLE.
- Latency: for start accepted at edge k, result_valid rises at edge k+S+Ndac*(T+1)+1, where S=max(sample_cycles,1) and T=settle_cycles.
- Output handshake: result_valid clears on an edge with result_ready=1, unless DONE writes a new result on the same edge, in which case it stays 1 with the new data.
- start while busy is ignored; no queueing. A start on the same edge that DONE exits is ignored; a start is accepted one cycle later in IDLE.
- overrun_clr has priority below a same-edge overrun set (set wins).
- Configuration inputs changing mid-conversion have no effect.
- Reset mid-conversion: all outputs drop to their reset values immediately; no partial result.

Decomposition:
- Shared package sar_pkg holds:
  - the state enum (IDLE, SAMPLE, TRIAL, DONE);
  - default widths for SAMPLE_W and SETTLE_W;
  - a localparam helper for index width, clog2(Ndac).
- One sub-module, sar_result_reg: the valid/ready output register with overrun detection. The FSM, counters and trial-code logic stay in sar_sequencer.

Test Plan:
- Ndac=4, S=2, T=0, chop_en=0, comparator modelled as "keep if trial ≤ 4'b1010" -> dac_state steps 1000, 1100, 1010, 1011. Result is 4'b1010, result_inv=0, result_valid at edge k+7.
- Same settings with T=3 -> each trial code holds 4 cycles; result_valid at edge k+19; result unchanged.
- chop_en=1, two back-to-back conversions with comparator output inverted in the model -> dac_drive_invert toggles 1 then 0. Both results are 1010, with result_inv 1 then 0.
- sample_cycles=0 -> sample high for exactly 1 cycle. start pulsed while busy -> ignored, with only one result produced.
- result_ready=0 across two conversions -> second result overwrites the first and overrun=1. overrun_clr=1 -> overrun returns to 0.
- rst_n asserted during TRIAL bit 2 -> all outputs 0 asynchronously. After release, a new start converts normally.
